// File: rtl/cdb_broadcast_queue.sv
// cdb_broadcast_queue
//   Collects finished results from NUM_FU functional units, picks one per
//   cycle round-robin, buffers it in a DEPTH-entry FIFO and presents the FIFO
//   head on the common data bus.
//
//   Handshake semantics (both sides follow strict valid/ready rules):
//     FU side : fu_done[i] is the valid and is held with its payload until
//               fu_queued[i] is seen; fu_queued[i] is the ready and is a
//               one-hot combinational grant. A transfer happens in a cycle
//               where both are high.
//     CDB side: cdb_valid/cdb_tag/cdb_data describe the head entry; the
//               entry leaves in any cycle where cdb_valid & cdb_ready.
//               cdb_ready is ignored while cdb_valid is low.
//
//   Optional feature macro: CDB_BYPASS_EN
//     When defined, a grant into an empty queue with cdb_ready high is
//     forwarded straight onto the CDB in the same cycle and not stored.
module cdb_broadcast_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 7,
    parameter int NUM_FU     = 4,
    parameter int DEPTH      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_FU-1:0]             fu_done,
    input  logic [NUM_FU*TAG_WIDTH-1:0]   fu_tag,
    input  logic [NUM_FU*DATA_WIDTH-1:0]  fu_result,
    output logic [NUM_FU-1:0]             fu_queued,
    output logic                          cdb_valid,
    output logic [TAG_WIDTH-1:0]          cdb_tag,
    output logic [DATA_WIDTH-1:0]         cdb_data,
    input  logic                          cdb_ready,
    output logic [$clog2(DEPTH):0]        occupancy
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int OCC_W   = PTR_W + 1;
    localparam int RR_W    = $clog2(NUM_FU);
    localparam int ENTRY_W = TAG_WIDTH + DATA_WIDTH;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [RR_W-1:0]    rr_ptr;

    logic               fifo_pop;
    logic               fifo_push;
    logic               can_accept;
    logic               bypass;
    logic               grant_any;
    logic [RR_W-1:0]    grant_idx;
    logic [RR_W:0]      scan_idx;
    logic [ENTRY_W-1:0] new_entry;
    logic [ENTRY_W-1:0] head_entry;

    // A pop frees a slot in the same cycle, so a full queue can still accept.
    assign fifo_pop   = (occupancy != '0) & cdb_ready;
    assign can_accept = (occupancy < OCC_W'(DEPTH)) | fifo_pop;

    // Round-robin scan starting at rr_ptr; the first requester wins.
    // Grants are suppressed while in reset or when there is no room.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            scan_idx = {1'b0, rr_ptr} + (RR_W+1)'(k);
            if (scan_idx >= (RR_W+1)'(NUM_FU)) begin
                scan_idx = scan_idx - (RR_W+1)'(NUM_FU);
            end
            if (!grant_any && fu_done[scan_idx[RR_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx[RR_W-1:0];
            end
        end
        if (rst || !can_accept) begin
            grant_any = 1'b0;
        end
    end

    // One-hot grant back to the winning FU.
    always_comb begin
        fu_queued = '0;
        if (grant_any) begin
            fu_queued[grant_idx] = 1'b1;
        end
    end

    assign new_entry  = {fu_tag[grant_idx*TAG_WIDTH +: TAG_WIDTH],
                         fu_result[grant_idx*DATA_WIDTH +: DATA_WIDTH]};
    assign head_entry = mem[rd_ptr];

`ifdef CDB_BYPASS_EN
    // Empty queue, fresh grant and a ready consumer: skip the storage.
    assign bypass = grant_any & (occupancy == '0) & cdb_ready;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_push = grant_any & ~bypass;

    // CDB shows the FIFO head, or the forwarded entry when bypassing.
    always_comb begin
        cdb_valid = (occupancy != '0) | bypass;
        if (bypass) begin
            {cdb_tag, cdb_data} = new_entry;
        end else begin
            {cdb_tag, cdb_data} = head_entry;
        end
    end

    // Pointers, occupancy and round-robin pointer; reset drops all entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
            rr_ptr    <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (fifo_push && !fifo_pop) begin
                occupancy <= occupancy + 1'b1;
            end else if (fifo_pop && !fifo_push) begin
                occupancy <= occupancy - 1'b1;
            end
            if (grant_any) begin
                if (grant_idx == RR_W'(NUM_FU-1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= grant_idx + 1'b1;
                end
            end
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

endmodule

// File: tb/tb_cdb_broadcast_queue.sv
// tb_cdb_broadcast_queue
//   Directed sequence against cdb_broadcast_queue with a reference queue of
//   expected CDB entries. Honours CDB_BYPASS_EN when it is defined.
module tb_cdb_broadcast_queue;

    localparam int DATA_WIDTH = 32;
    localparam int TAG_WIDTH  = 7;
    localparam int NUM_FU     = 4;
    localparam int DEPTH      = 8;
    localparam int W          = TAG_WIDTH + DATA_WIDTH;

    logic                          clk;
    logic                          rst;
    logic [NUM_FU-1:0]             fu_done;
    logic [NUM_FU*TAG_WIDTH-1:0]   fu_tag;
    logic [NUM_FU*DATA_WIDTH-1:0]  fu_result;
    logic [NUM_FU-1:0]             fu_queued;
    logic                          cdb_valid;
    logic [TAG_WIDTH-1:0]          cdb_tag;
    logic [DATA_WIDTH-1:0]         cdb_data;
    logic                          cdb_ready;
    logic [$clog2(DEPTH):0]        occupancy;

    logic [TAG_WIDTH-1:0]  tag_a [NUM_FU];
    logic [DATA_WIDTH-1:0] res_a [NUM_FU];
    logic [W-1:0]          exp_q [$];
    int                    rr_m;
    int                    n_checks;
    int                    n_fail;

    cdb_broadcast_queue #(
        .DATA_WIDTH(DATA_WIDTH),
        .TAG_WIDTH (TAG_WIDTH),
        .NUM_FU    (NUM_FU),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fu_done   (fu_done),
        .fu_tag    (fu_tag),
        .fu_result (fu_result),
        .fu_queued (fu_queued),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_ready (cdb_ready),
        .occupancy (occupancy)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pack_payload();
        for (int i = 0; i < NUM_FU; i++) begin
            fu_tag[i*TAG_WIDTH +: TAG_WIDTH]      = tag_a[i];
            fu_result[i*DATA_WIDTH +: DATA_WIDTH] = res_a[i];
        end
    endtask

    task automatic rand_payload();
        for (int i = 0; i < NUM_FU; i++) begin
            tag_a[i] = TAG_WIDTH'($urandom_range(0, 127));
            res_a[i] = $urandom;
        end
        pack_payload();
    endtask

    // One clock of stimulus. Entered and left at posedge+1.
    task automatic step(input string name, input logic [NUM_FU-1:0] done,
                        input logic ready, input logic keep_payload);
        int           occ_m;
        bit           pop_m;
        bit           acc_m;
        bit           found;
        int           g;
        bit           byp_m;
        bit           exp_valid;
        logic [W-1:0] new_e;
        logic [W-1:0] head_e;
        logic [NUM_FU-1:0] exp_grant;
        if (!keep_payload) rand_payload();
        fu_done   = done;
        cdb_ready = ready;

        occ_m = exp_q.size();
        pop_m = (occ_m != 0) && ready;
        acc_m = (occ_m < DEPTH) || pop_m;
        found = 1'b0;
        g     = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            int idx;
            idx = (rr_m + k) % NUM_FU;
            if (!found && done[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
        if (!acc_m) found = 1'b0;
        exp_grant = '0;
        if (found) exp_grant[g] = 1'b1;
        new_e = {tag_a[g], res_a[g]};
`ifdef CDB_BYPASS_EN
        byp_m = found && (occ_m == 0) && ready;
`else
        byp_m = 1'b0;
`endif
        exp_valid = (occ_m != 0) || byp_m;
        head_e    = (occ_m != 0) ? exp_q[0] : new_e;

        @(negedge clk);
        check({name, "_grant"}, 64'(fu_queued), 64'(exp_grant));
        check({name, "_valid"}, 64'(cdb_valid), 64'(exp_valid));
        check({name, "_occ"}, 64'(occupancy), 64'(occ_m));
        if (exp_valid) check({name, "_cdb"}, 64'({cdb_tag, cdb_data}), 64'(head_e));

        if (pop_m) void'(exp_q.pop_front());
        if (found && !byp_m) exp_q.push_back(new_e);
        if (found) rr_m = (g + 1) % NUM_FU;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [NUM_FU-1:0] done);
        rst       = 1'b1;
        fu_done   = done;
        cdb_ready = 1'b1;
        @(negedge clk);
        check("rst_grant", 64'(fu_queued), 64'(0));
        @(posedge clk);
        #1;
        rst     = 1'b0;
        fu_done = '0;
        exp_q.delete();
        rr_m = 0;
        #1;
        check("rst_valid", 64'(cdb_valid), 64'(0));
        check("rst_occ", 64'(occupancy), 64'(0));
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rr_m      = 0;
        rst       = 1'b1;
        fu_done   = '0;
        cdb_ready = 1'b0;
        rand_payload();
        repeat (2) @(posedge clk);
        #1;
        do_reset('0);

        // Test 1: single result from FU1
        rand_payload();
        tag_a[1] = 7'h05;
        res_a[1] = 32'h1234;
        pack_payload();
        step("t1_req", 4'b0010, 1'b1, 1'b1);
        step("t1_out", 4'b0000, 1'b1, 1'b0);
        step("t1_empty", 4'b0000, 1'b1, 1'b0);

        // Test 2: all FUs requesting, consumer always ready
        for (int i = 0; i < 6; i++) step("t2_rr", 4'b1111, 1'b1, 1'b0);
        step("t2_drain", 4'b0000, 1'b1, 1'b0);
        step("t2_drain", 4'b0000, 1'b1, 1'b0);

        // Test 3: fill to full, stall, then simultaneous pop and grant
        do_reset('0);
        for (int i = 0; i < DEPTH + 2; i++) step("t3_fill", 4'b0001, 1'b0, 1'b0);
        step("t3_popgrant", 4'b0001, 1'b1, 1'b0);
        step("t3_full", 4'b0001, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) step("t3_drain", 4'b0000, 1'b1, 1'b0);

        // Test 4: partial fill/drain then refill across the wrap point
        for (int i = 0; i < 3; i++) step("t4_fill", 4'b0100, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("t4_drain", 4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) step("t4_refill", 4'b1010, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step("t4_mix", NUM_FU'($urandom_range(0, 15)), 1'(i), 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) step("t4_drain2", 4'b0000, 1'b1, 1'b0);

        // Test 5: reset with entries held and all FUs requesting
        for (int i = 0; i < 5; i++) step("t5_fill", 4'b0110, 1'b0, 1'b0);
        check("t5_occ", 64'(occupancy), 64'(5));
        do_reset(4'b1111);
        step("t5_first", 4'b1111, 1'b0, 1'b0);
        check("t5_first_fu0", 64'(exp_q.size() + rr_m), 64'(2));
        for (int i = 0; i < 3; i++) step("t5_drain", 4'b0000, 1'b1, 1'b0);
        check("final_empty", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
